// File: rtl/display_refresh_scanner_pkg.sv
// disp_pkg: shared constants and types for the seven-segment display path.
package disp_pkg;
  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W = 4;
  localparam int DEFAULT_TICK_DIV = 100000;
  typedef logic [1:0] digit_idx_t;
endpackage

// File: rtl/display_refresh_scanner_if.sv
// display_refresh_scanner_if: load strobe/data in, scanned digit outputs back.
interface display_refresh_scanner_if;
  import disp_pkg::*;
  logic [NUM_DIGITS*DIGIT_W-1:0] value_in;
  logic [NUM_DIGITS-1:0] blank_in;
  logic value_load;
  logic load_pending;
  digit_idx_t refresh_cntr;
  logic [DIGIT_W-1:0] digit_val;
  logic digit_blank;
  logic frame_done;
  modport master(output value_in, blank_in, value_load,
                 input load_pending, refresh_cntr, digit_val, digit_blank, frame_done);
  modport slave(input value_in, blank_in, value_load,
                output load_pending, refresh_cntr, digit_val, digit_blank, frame_done);
endinterface

// File: rtl/display_refresh_scanner_prescaler.sv
// refresh_prescaler: divides clk into a one-cycle tick every TICK_DIV cycles.
module refresh_prescaler
  import disp_pkg::*;
#(
  parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int W = $clog2(TICK_DIV);
  logic [W-1:0] cnt;
  assign tick = cnt == W'(TICK_DIV - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/display_refresh_scanner.sv
// display_refresh_scanner: digit refresh scan with frame-aligned double-buffered value.
// Optional LEAD_ZERO_BLANK_EN auto-blanks leading zero digits (never digit 0).
module display_refresh_scanner
  import disp_pkg::*;
#(
  parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
  input logic clk,
  input logic rst_n,
  display_refresh_scanner_if.slave bus
);
  logic tick;
  logic boundary;
  digit_idx_t cntr;
  logic frame_done;
  logic pending;
  logic [NUM_DIGITS*DIGIT_W-1:0] stage_val, act_val;
  logic [NUM_DIGITS-1:0] stage_blank, act_blank, lz_blank;
  refresh_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );
  assign boundary = tick && cntr == 2'd3;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cntr <= '0;
      frame_done <= 1'b0;
      pending <= 1'b0;
      stage_val <= '0;
      act_val <= '0;
      stage_blank <= '1;
      act_blank <= '1;
    end else begin
      if (tick) cntr <= cntr + 1'b1;
      frame_done <= boundary;
      pending <= !boundary && (pending || bus.value_load);
      if (bus.value_load) begin
        stage_val <= bus.value_in;
        stage_blank <= bus.blank_in;
      end
      // A load coinciding with the boundary bypasses staging straight to active.
      if (boundary && bus.value_load) begin
        act_val <= bus.value_in;
        act_blank <= bus.blank_in;
      end else if (boundary && pending) begin
        act_val <= stage_val;
        act_blank <= stage_blank;
      end
    end
`ifdef LEAD_ZERO_BLANK_EN
  always_comb begin
    lz_blank[3] = act_val[15:12] == '0;
    lz_blank[2] = lz_blank[3] && act_val[11:8] == '0;
    lz_blank[1] = lz_blank[2] && act_val[7:4] == '0;
    lz_blank[0] = 1'b0;
  end
`else
  assign lz_blank = '0;
`endif
  assign bus.refresh_cntr = cntr;
  assign bus.frame_done = frame_done;
  assign bus.load_pending = pending;
  assign bus.digit_val = act_val[{cntr, 2'b00} +: DIGIT_W];
  assign bus.digit_blank = act_blank[cntr] | lz_blank[cntr];
endmodule

// File: tb/tb_display_refresh_scanner.sv
// tb_display_refresh_scanner: randomized and directed checks against a frame-level model.
module tb_display_refresh_scanner;
  logic clk = 1'b0;
  logic rst_n;
  int pass_cnt = 0;
  int tot_cnt = 0;
`ifdef LEAD_ZERO_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif
  display_refresh_scanner_if bus ();
  display_refresh_scanner #(.TICK_DIV(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );
  always #5 clk = ~clk;

  // Model: n counts edges since reset; every 4 edges is a slot, every 16 a frame.
  int n;
  logic [15:0] m_stage, m_act;
  logic [3:0] m_sb, m_ab;
  bit m_pend;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      n = 0;
      m_stage = 16'h0;
      m_act = 16'h0;
      m_sb = 4'hF;
      m_ab = 4'hF;
      m_pend = 0;
    end else begin
      bit bnd;
      bnd = (n % 16) == 15;
      if (bus.value_load) begin
        m_stage = bus.value_in;
        m_sb = bus.blank_in;
        m_pend = 1;
      end
      if (bnd) begin
        if (m_pend) begin
          m_act = m_stage;
          m_ab = m_sb;
        end
        m_pend = 0;
      end
      n++;
    end

  function automatic bit lz_of(logic [15:0] v, int d);
    return LZ && d > 0 && (v >> (4 * d)) == 16'h0;
  endfunction

  task automatic check(string name, logic [15:0] got, logic [15:0] exp);
    tot_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  always @(negedge clk)
    if (rst_n) begin
      int rc;
      rc = (n / 4) % 4;
      check("rc", 16'(bus.refresh_cntr), 16'(rc));
      check("frame_done", 16'(bus.frame_done), 16'(n > 0 && n % 16 == 0));
      check("pending", 16'(bus.load_pending), 16'(m_pend));
      check("digit_val", 16'(bus.digit_val), (m_act >> (4 * rc)) & 16'hF);
      check("digit_blank", 16'(bus.digit_blank), 16'(m_ab[rc] | lz_of(m_act, rc)));
    end

  task automatic wait_frame();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.frame_done) return;
    end
    check("frame_timeout", 16'h0, 16'h1);
  endtask

  task automatic load(logic [15:0] v, logic [3:0] b);
    bus.value_load = 1'b1;
    bus.value_in = v;
    bus.blank_in = b;
    @(negedge clk);
    bus.value_load = 1'b0;
  endtask

  // Called at a frame-start negedge; walks four slots with literal expectations.
  task automatic show(logic [15:0] v, logic [3:0] b);
    for (int d = 0; d < 4; d++) begin
      check($sformatf("lit_rc%0d", d), 16'(bus.refresh_cntr), 16'(d));
      check($sformatf("lit_val%0d", d), 16'(bus.digit_val), (v >> (4 * d)) & 16'hF);
      check($sformatf("lit_blank%0d", d), 16'(bus.digit_blank), 16'(b[d]));
      repeat (4) @(negedge clk);
    end
  endtask

  initial begin
    int first;
    rst_n = 1'b0;
    bus.value_load = 1'b0;
    bus.value_in = '0;
    bus.blank_in = '0;
    repeat (3) @(negedge clk);
    check("rst_rc", 16'(bus.refresh_cntr), 16'h0);
    check("rst_pending", 16'(bus.load_pending), 16'h0);
    check("rst_blank", 16'(bus.digit_blank), 16'h1);
    check("rst_fd", 16'(bus.frame_done), 16'h0);
    rst_n = 1'b1;
    first = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.frame_done && first == 0) first = i;
    end
    check("first_frame_cycle", 16'(first), 16'd16);
    load(16'h1234, 4'h0);
    check("pending_after_load", 16'(bus.load_pending), 16'h1);
    wait_frame();
    check("pending_after_bnd", 16'(bus.load_pending), 16'h0);
    show(16'h1234, 4'h0);
    load(16'hAAAA, 4'h0);
    load(16'h5555, 4'h0);
    wait_frame();
    show(16'h5555, 4'h0);
    repeat (15) @(negedge clk);
    load(16'h00F0, 4'h0);
    check("bnd_load_fd", 16'(bus.frame_done), 16'h1);
    check("bnd_load_pending", 16'(bus.load_pending), 16'h0);
    show(16'h00F0, 4'h0);
    load(16'h1234, 4'h0);
    wait_frame();
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rc", 16'(bus.refresh_cntr), 16'h0);
    check("async_pending", 16'(bus.load_pending), 16'h0);
    check("async_blank", 16'(bus.digit_blank), 16'h1);
    check("async_fd", 16'(bus.frame_done), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    load(16'h0042, 4'h0);
    wait_frame();
    show(16'h0042, LZ ? 4'b1100 : 4'b0000);
    load(16'h0000, 4'h0);
    wait_frame();
    show(16'h0000, LZ ? 4'b1110 : 4'b0000);
    for (int i = 0; i < 400; i++) begin
      bus.value_load = $urandom_range(0, 7) == 0;
      bus.value_in = 16'($urandom);
      bus.blank_in = 4'($urandom);
      @(negedge clk);
    end
    bus.value_load = 1'b0;
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
